// File: rtl/floo_pkg.sv
// floo_pkg: shared routing types, direction indices and the per-VC route lock record.
package floo_pkg;
  typedef enum logic [1:0] {XYRouting, SourceRouting, IdTable} route_algo_e;
  localparam int unsigned North = 0;
  localparam int unsigned East = 1;
  localparam int unsigned South = 2;
  localparam int unsigned West = 3;
  localparam int unsigned Eject = 4;
  localparam int unsigned NumRoutesDflt = 5;
  localparam int unsigned SelIdWidthDflt = $clog2(NumRoutesDflt);
  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } id_t;
  typedef struct packed {
    logic last;
    id_t dst_id;
  } hdr_t;
  typedef struct packed {
    hdr_t hdr;
    logic [15:0] payload;
  } flit_t;
  typedef struct packed {
    logic [SelIdWidthDflt-1:0] idx;
    id_t start_addr;
    id_t end_addr;
  } addr_rule_t;
  typedef struct packed {
    logic locked;
    logic [NumRoutesDflt-1:0] sel;
    logic [SelIdWidthDflt-1:0] sel_id;
  } vc_route_lock_t;
endpackage

// File: rtl/floo_vc_route_select_if.sv
// floo_vc_route_select_if: input/output flit handshake bundle of the route selection stage.
interface floo_vc_route_select_if import floo_pkg::*; #(
  parameter int unsigned NumRoutes = 5,
  parameter int unsigned RouteSelWidth = 3,
  parameter int unsigned VcIdWidth = 1
);
  logic valid_i, ready_o, valid_o, ready_i, err_o;
  flit_t channel_i, channel_o;
  logic [VcIdWidth-1:0] vc_id_i, vc_id_o;
  logic [NumRoutes-1:0] route_sel_o;
  logic [RouteSelWidth-1:0] route_sel_id_o;
  modport slave(
    input valid_i, channel_i, vc_id_i, ready_i,
    output ready_o, valid_o, channel_o, vc_id_o, route_sel_o, route_sel_id_o, err_o
  );
  modport master(
    output valid_i, channel_i, vc_id_i, ready_i,
    input ready_o, valid_o, channel_o, vc_id_o, route_sel_o, route_sel_id_o, err_o
  );
endinterface

// File: rtl/floo_route_comp.sv
// floo_route_comp: combinational output-port computation for XY, source and ID-table routing.
module floo_route_comp import floo_pkg::*; #(
  parameter route_algo_e RouteAlgo = XYRouting,
  parameter int unsigned IdWidth = $bits(id_t),
  parameter int unsigned NumAddrRules = 0,
  parameter int unsigned RouteSelWidth = 3
) (
  input  id_t xy_id_i,
  input  addr_rule_t [(NumAddrRules > 0 ? NumAddrRules : 1)-1:0] id_route_map_i,
  input  id_t dst_id_i,
  output id_t dst_id_o,
  output logic [RouteSelWidth-1:0] sel_id_o
);
  logic [IdWidth-1:0] dst_vec;
  logic unused;
  assign dst_vec = dst_id_i;
  assign unused = ^{xy_id_i, id_route_map_i, dst_vec};
  if (RouteAlgo == SourceRouting) begin : g_src
    assign sel_id_o = dst_vec[RouteSelWidth-1:0];
    assign dst_id_o = id_t'(dst_vec >> RouteSelWidth);
  end else if (RouteAlgo == IdTable) begin : g_tbl
    assign dst_id_o = dst_id_i;
    // Later matching rules override earlier ones; a miss falls back to port 0.
    always_comb begin
      sel_id_o = '0;
      for (int unsigned r = 0; r < NumAddrRules; r++)
        if (dst_vec >= IdWidth'(id_route_map_i[r].start_addr) && dst_vec < IdWidth'(id_route_map_i[r].end_addr))
          sel_id_o = RouteSelWidth'(id_route_map_i[r].idx);
    end
  end else begin : g_xy
    assign dst_id_o = dst_id_i;
    assign sel_id_o = RouteSelWidth'(dst_id_i.x < xy_id_i.x ? West :
                                     dst_id_i.x > xy_id_i.x ? East :
                                     dst_id_i.y < xy_id_i.y ? South :
                                     dst_id_i.y > xy_id_i.y ? North : Eject);
  end
endmodule

// File: rtl/floo_vc_route_select.sv
// floo_vc_route_select: registered VC-aware route selection with a per-VC route lock.
// Define FLOO_ROUTE_CHECK_EN to build the sticky locked-route mismatch flag err_o.
module floo_vc_route_select import floo_pkg::*; #(
  parameter int unsigned NumRoutes = NumRoutesDflt,
  parameter int unsigned NumVirtChannels = 2,
  parameter route_algo_e RouteAlgo = XYRouting,
  parameter int unsigned IdWidth = $bits(id_t),
  parameter int unsigned NumAddrRules = 0,
  parameter int unsigned RouteSelWidth = $clog2(NumRoutes),
  parameter int unsigned VcIdWidth = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic test_enable_i,
  input  id_t  xy_id_i,
  input  addr_rule_t [(NumAddrRules > 0 ? NumAddrRules : 1)-1:0] id_route_map_i,
  floo_vc_route_select_if.slave bus
);
  vc_route_lock_t [NumVirtChannels-1:0] lock_q, lock_d;
  flit_t flit_q, flit_d;
  logic [VcIdWidth-1:0] vc_q;
  logic [NumRoutes-1:0] route_q, route_d;
  logic [RouteSelWidth-1:0] route_id_q, route_id_d, comp_id;
  id_t dst_id;
  logic full_q, vc_ok, locked, in_hs, unused_test_en;
  floo_route_comp #(
    .RouteAlgo(RouteAlgo),
    .IdWidth(IdWidth),
    .NumAddrRules(NumAddrRules),
    .RouteSelWidth(RouteSelWidth)
  ) u_comp (
    .xy_id_i(xy_id_i),
    .id_route_map_i(id_route_map_i),
    .dst_id_i(bus.channel_i.hdr.dst_id),
    .dst_id_o(dst_id),
    .sel_id_o(comp_id)
  );
  assign unused_test_en = test_enable_i;
  assign bus.ready_o = ~full_q | bus.ready_i;
  assign in_hs = bus.valid_i && bus.ready_o;
  // Out-of-range VC tags bypass the lock table entirely.
  assign vc_ok = 32'(bus.vc_id_i) < NumVirtChannels;
  assign locked = vc_ok && lock_q[bus.vc_id_i].locked;
  assign route_id_d = locked ? RouteSelWidth'(lock_q[bus.vc_id_i].sel_id) : comp_id;
  assign route_d = locked ? NumRoutes'(lock_q[bus.vc_id_i].sel) : NumRoutes'(1) << comp_id;
  always_comb begin
    flit_d = bus.channel_i;
    flit_d.hdr.dst_id = dst_id;
    lock_d = lock_q;
    if (in_hs && vc_ok) begin
      lock_d[bus.vc_id_i].locked = ~bus.channel_i.hdr.last;
      if (!locked) begin
        lock_d[bus.vc_id_i].sel = NumRoutesDflt'(route_d);
        lock_d[bus.vc_id_i].sel_id = SelIdWidthDflt'(comp_id);
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      lock_q <= '0;
      flit_q <= '0;
      vc_q <= '0;
      route_q <= '0;
      route_id_q <= '0;
    end else begin
      lock_q <= lock_d;
      if (in_hs) begin
        full_q <= 1'b1;
        flit_q <= flit_d;
        vc_q <= bus.vc_id_i;
        route_q <= route_d;
        route_id_q <= route_id_d;
      end else if (bus.ready_i) begin
        full_q <= 1'b0;
      end
    end
  end
  assign bus.valid_o = full_q;
  assign bus.channel_o = flit_q;
  assign bus.vc_id_o = vc_q;
  assign bus.route_sel_o = route_q;
  assign bus.route_sel_id_o = route_id_q;
`ifdef FLOO_ROUTE_CHECK_EN
  logic err_q, mismatch;
  assign mismatch = in_hs && locked && comp_id != RouteSelWidth'(lock_q[bus.vc_id_i].sel_id);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (mismatch) err_q <= 1'b1;
  end
  assign bus.err_o = err_q;
`ifndef SYNTHESIS
  always @(posedge clk_i) if (!rst_i && mismatch) $warning("locked route differs from header on VC %0d", bus.vc_id_i);
`endif
`else
  assign bus.err_o = 1'b0;
`endif
endmodule
